// File: rtl/sha3_result_collector.sv
// rtl/sha3_result_collector.sv - FWFT result FIFO sampling scanner captures for the register layer.
// Optional SHA3_COLLECTOR_TIMESTAMP_EN stores scan_count with each entry and presents it on rd_stamp.
module sha3_result_collector #(
  parameter int DEPTH      = 8,
  parameter int HASH_WORD  = 0,
  parameter int DROP_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    capture,
  input  logic [31:0]             nonce,
  input  logic [64*25-1:0]        hash,
  input  logic [31:0]             scan_count,
  output logic                    rd_valid,
  output logic [31:0]             rd_nonce,
  output logic [63:0]             rd_hash,
  output logic [31:0]             rd_stamp,
  input  logic                    rd_pop,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] dropped_q, dropped_d;
  logic                  do_pop, do_push, do_write;

  logic [31:0] nonce_mem [DEPTH];
  logic [63:0] hash_mem  [DEPTH];

  logic unused_inputs;
  assign unused_inputs = ^{hash, scan_count};

  always_comb begin
    do_pop     = rd_pop && (level_q != '0);
    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    do_push    = capture && ((level_q != FULL_LEVEL) || do_pop);
    do_write   = do_push && !start;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    if (start) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      dropped_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (do_pop && !do_push) level_d = level_q - 1'b1;
      if (capture && !do_push) begin
        overflow_d = 1'b1;
        if (dropped_q != '1) dropped_d = dropped_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      nonce_mem[wr_ptr_q] <= nonce;
      hash_mem[wr_ptr_q]  <= hash[HASH_WORD*64 +: 64];
    end
  end

  assign rd_valid = (level_q != '0);
  assign rd_nonce = rd_valid ? nonce_mem[rd_ptr_q] : '0;
  assign rd_hash  = rd_valid ? hash_mem[rd_ptr_q]  : '0;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign dropped  = dropped_q;

`ifdef SHA3_COLLECTOR_TIMESTAMP_EN
  logic [31:0] stamp_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (do_write) stamp_mem[wr_ptr_q] <= scan_count;
  end

  assign rd_stamp = rd_valid ? stamp_mem[rd_ptr_q] : '0;
`else
  assign rd_stamp = '0;
`endif

endmodule

// File: doc/sha3_result_collector.md
Name: sha3_result_collector

Overview:
- Receiving end of the scanner result interface: samples every `ocapture` pulse from `sha3_packed_pipeline_scanner`, with its nonce and one selected hash word, into a small FIFO.
- The AXI device register layer drains the FIFO at its own pace, so back-to-back captures are not lost while software polls.
- Sits between the scanner and the AXI slave register file, all in the `clk` domain.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- HASH_WORD, 0, index 0..24 of `ohash[]` stored per entry.
- DROP_CNT_W, 16, width of the saturating dropped-result counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  scan start pulse, same signal the scanner receives; flushes the collector.
- capture  in  1  one-cycle result strobe, driven by scanner `ocapture`.
- nonce  in  32  scanner `ononce`; valid when capture=1.
- hash  in  64x25  scanner `ohash`; valid when capture=1.
- scan_count  in  32  scanner `scan_count`; used only with the optional feature.
- rd_valid  out  1  FIFO head valid, i.e. FIFO not empty.
- rd_nonce  out  32  head-entry nonce.
- rd_hash  out  64  head-entry `hash[HASH_WORD]`.
- rd_stamp  out  32  head-entry `scan_count`; only with the optional feature, else tied 0.
- rd_pop  in  1  consume head; ignored when rd_valid=0.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one capture dropped since last start/reset.
- dropped  out  DROP_CNT_W  count of dropped captures, saturating at all-ones.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - read/write pointers, level, overflow and dropped go to 0; rd_valid=0.
  - storage RAM is not reset; rd_nonce, rd_hash and rd_stamp read as 0 while rd_valid=0.
- Storage: circular buffer of DEPTH entries {nonce, hash word[, stamp]}.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - level is a separate counter.
- Output is first-word-fall-through:
  - rd_* always present the entry at rd_ptr.
  - rd_valid = (level != 0).
  - A capture into an empty FIFO at edge N gives rd_valid=1 with that data after edge N (one-cycle latency).
- Push: capture=1 and (level<DEPTH, or level==DEPTH with an effective pop in the same cycle) writes at wr_ptr, then wr_ptr+1.
- Pop: rd_pop=1 and rd_valid=1 advance rd_ptr by 1.
- Level update per edge:
  - +1 on push only.
  - -1 on effective pop only.
  - unchanged on both or neither.
- Full with simultaneous capture and pop: both take effect, level stays DEPTH, no drop.
- Full with capture and no pop: entry discarded, FIFO contents untouched, overflow<=1, dropped<=dropped+1 unless already all-ones.
- Empty with rd_pop=1: no effect; pointers and level unchanged.
- start=1 (synchronous flush):
  - pointers, level, overflow and dropped go to 0 at that edge.
  - start has priority over capture and rd_pop in the same cycle; such a capture is discarded and not counted as dropped.
- capture held high for consecutive cycles: each cycle is an independent push. The scanner never does this, but the block does not rely on it.
- No state machine beyond the pointer/level logic; rst_n asserted mid-stream aborts everything immediately.

Optional Feature:
- SHA3_COLLECTOR_TIMESTAMP_EN
- Defined:
  - each entry also stores scan_count sampled on the capture cycle.
  - rd_stamp presents the stored value of the head entry.
- Undefined: no stamp storage is instantiated and rd_stamp is constant 0.
- All other behaviour is identical either way.

Test Plan:
- Reset, then one capture with nonce=0x0000_1234 and hash[0]=0xDEAD_BEEF_0000_0001 -> next cycle rd_valid=1, rd_nonce=0x1234, rd_hash=0xDEADBEEF00000001, level=1; pop -> rd_valid=0, level=0.
- DEPTH=8: 10 captures, no pops, nonces 1..10 -> level=8, overflow=1, dropped=2; popping yields nonces 1..8 in order.
- Full FIFO, capture nonce=99 with rd_pop in the same cycle -> level stays 8, dropped unchanged; the last popped entry is 99.
- start asserted with capture in the same cycle, FIFO holding 3 entries -> level=0, rd_valid=0, overflow=0, dropped=0; that capture is not stored.
- rst_n pulsed low mid-stream, unaligned to clk -> all outputs 0 immediately; rd_pop on the empty FIFO afterwards leaves level=0.
- With SHA3_COLLECTOR_TIMESTAMP_EN: captures at scan_count=5 and 17 -> rd_stamp reads 5, then 17 after the pop. Without the macro, rd_stamp=0 throughout.
